// File: rtl/exc_sequencer_if.sv
// rtl/exc_sequencer_if.sv - datapath handshake bundle between exc_sequencer and the CP0 datapath
//
// Purpose: carries the exception-entry request/acknowledge handshake and the
// ERET return pulse between the sequencer and the datapath.
//
// Signals:
//   exc_req     sequencer -> datapath  request exception entry
//   exc_id      sequencer -> datapath  index of the granted source (IDW bits)
//   exc_cause   sequencer -> datapath  32-bit cause code of the granted source
//   in_service  sequencer -> datapath  handler running, new entries blocked
//   exc_ack     datapath -> sequencer  request accepted, EPC saved this cycle
//   eret        datapath -> sequencer  ERET retired, one-cycle pulse
//
// Modports: master = sequencer side, slave = datapath side.

interface exc_sequencer_if #(
  parameter int IDW = 2
);
  logic           exc_req;
  logic [IDW-1:0] exc_id;
  logic [31:0]    exc_cause;
  logic           in_service;
  logic           exc_ack;
  logic           eret;

  modport master (
    output exc_req,
    output exc_id,
    output exc_cause,
    output in_service,
    input  exc_ack,
    input  eret
  );

  modport slave (
    input  exc_req,
    input  exc_id,
    input  exc_cause,
    input  in_service,
    output exc_ack,
    output eret
  );
endinterface

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - fixed-priority exception/interrupt sequencer in front of CP0
//
// Purpose: edge-captures N exception sources into pending latches, applies the
// per-source mask and the global block, grants the lowest-index eligible source
// and runs a req/ack handshake with the datapath. Entry stays blocked until ERET.
// Fully synchronous to clk; clr is an asynchronous active-high reset.
//
// Ports:
//   clk         in   system clock, rising edge
//   clr         in   asynchronous active-high reset
//   src         in   N raw exception lines (level); a 0->1 transition is an event
//   mask_we     in   mask register write strobe
//   mask_wdata  in   N new mask value, bit=1 disables that source
//   pend_clr    in   N software clear of pending bits (one-cycle pulse per bit)
//   int_block   in   global block, 1 = no new entry
//   dp          if   datapath handshake (master side): exc_req, exc_id, exc_cause,
//                    in_service out; exc_ack, eret in
//   pending     out  N current pending latches
//   mask        out  N current mask register
//
// Parameters: N = number of sources (1..31, index 0 highest priority),
//             IDW = width of exc_id (2**IDW >= N).

module exc_sequencer #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    src,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_wdata,
  input  logic [N-1:0]    pend_clr,
  input  logic            int_block,
  exc_sequencer_if.master dp,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    mask
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] grant_d;
  logic [IDW-1:0] grant_next;

  logic [N-1:0]   src_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   eligible;
  logic [N-1:0]   grant_oh;
  logic [N-1:0]   clr_mask;
  logic [N-1:0]   pending_d;
  logic           ack_fire;
  logic           any_eligible;
  logic [31:0]    cause_val;

  // Edge detection: a line held high produces a single event.
  assign rise = src & ~src_q;

  // Masked sources still latch pending; they are only kept out of arbitration.
  assign eligible     = pending & ~mask;
  assign any_eligible = |eligible;

  // Fixed priority: scanning from the top down leaves the lowest set index.
  always_comb begin
    grant_next = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_next = IDW'(i);
      end
    end
  end

  assign ack_fire = (state_q == ST_REQ) && dp.exc_ack;
  assign grant_oh = N'(1) << grant_q;
  assign clr_mask = pend_clr | (ack_fire ? grant_oh : '0);

  // The rise term is ORed in after the clear so that an event arriving in the
  // same cycle as a software clear or an acknowledge is never lost.
  assign pending_d = (pending & ~clr_mask) | rise;

  // Cause code is a thermometer of grant+1 ones: src0=0x1, src1=0x3, src2=0x7.
  assign cause_val = (32'd1 << (int'(grant_q) + 1)) - 32'd1;

  // Next-state logic. Once in REQ the request is never withdrawn: mask writes,
  // pending clears and int_block changes are deliberately ignored until exc_ack.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible && !int_block) begin
          state_d = ST_REQ;
          grant_d = grant_next;
        end
      end
      ST_REQ: begin
        if (dp.exc_ack) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (dp.eret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. exc_id and exc_cause read zero while idle so that a stale
  // grant from the previous handler is never visible to the datapath.
  always_comb begin
    dp.exc_req    = 1'b0;
    dp.in_service = 1'b0;
    dp.exc_id     = '0;
    dp.exc_cause  = '0;
    case (state_q)
      ST_REQ: begin
        dp.exc_req   = 1'b1;
        dp.exc_id    = grant_q;
        dp.exc_cause = cause_val;
      end
      ST_SERVICE: begin
        dp.in_service = 1'b1;
        dp.exc_id     = grant_q;
        dp.exc_cause  = cause_val;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      src_q   <= src;
      pending <= pending_d;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - self-checking bench for exc_sequencer (vector table, directed and random)

module tb_exc_sequencer;

  logic       clk;
  logic       clr;
  logic [2:0] src;
  logic       mask_we;
  logic [2:0] mask_wdata;
  logic [2:0] pend_clr;
  logic       int_block;
  logic [2:0] pending;
  logic [2:0] mask;

  exc_sequencer_if #(.IDW(2)) bus ();

  exc_sequencer #(.N(3), .IDW(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend_clr   (pend_clr),
    .int_block  (int_block),
    .dp         (bus),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: which source owns the handler (-1 = none) and whether
  // the datapath has already accepted it.
  bit [2:0] m_pend;
  bit [2:0] m_mask;
  bit [2:0] m_prev;
  int       m_owner;
  bit       m_acked;

  typedef struct {
    logic [2:0]  src;
    logic        mask_we;
    logic [2:0]  mask_wdata;
    logic [2:0]  pend_clr;
    logic        int_block;
    logic        ack;
    logic        eret;
    logic        req;
    logic [1:0]  id;
    logic [31:0] cause;
    logic        svc;
    logic [2:0]  pend;
    logic [2:0]  msk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] s, input logic mw, input logic [2:0] md,
                              input logic [2:0] pc, input logic blk, input logic ak,
                              input logic er, input logic rq, input logic [1:0] id,
                              input logic [31:0] cs, input logic sv, input logic [2:0] pd,
                              input logic [2:0] mk_v);
    vec_t v;
    v.src = s; v.mask_we = mw; v.mask_wdata = md; v.pend_clr = pc; v.int_block = blk;
    v.ack = ak; v.eret = er; v.req = rq; v.id = id; v.cause = cs; v.svc = sv;
    v.pend = pd; v.msk = mk_v;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic rq, input logic [1:0] id,
                            input logic [31:0] cs, input logic sv, input logic [2:0] pd,
                            input logic [2:0] mk_v);
    check({tag, ".exc_req"},    32'(bus.exc_req),    32'(rq));
    check({tag, ".exc_id"},     32'(bus.exc_id),     32'(id));
    check({tag, ".exc_cause"},  bus.exc_cause,       cs);
    check({tag, ".in_service"}, 32'(bus.in_service), 32'(sv));
    check({tag, ".pending"},    32'(pending),        32'(pd));
    check({tag, ".mask"},       32'(mask),           32'(mk_v));
  endtask

  function automatic void model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_owner = -1; m_acked = 1'b0;
  endfunction

  function automatic void model_edge();
    int       pick;
    bit [2:0] np;
    pick = -1;
    for (int i = 2; i >= 0; i--)
      if (m_pend[2'(i)] && !m_mask[2'(i)]) pick = i;
    np = m_pend;
    if (m_owner < 0) begin
      if (pick >= 0 && !int_block) m_owner = pick;
    end else if (!m_acked) begin
      if (bus.exc_ack) begin
        m_acked = 1'b1;
        np[2'(m_owner)] = 1'b0;
      end
    end else if (bus.eret) begin
      m_owner = -1;
      m_acked = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (pend_clr[2'(i)]) np[2'(i)] = 1'b0;
      if (src[2'(i)] && !m_prev[2'(i)]) np[2'(i)] = 1'b1;
    end
    if (mask_we) m_mask = mask_wdata;
    m_prev = src;
    m_pend = np;
  endfunction

  task automatic model_check(input string tag);
    logic        rq;
    logic        sv;
    logic [1:0]  id;
    logic [31:0] cs;
    rq = (m_owner >= 0) && !m_acked;
    sv = m_acked;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    cs = (m_owner >= 0) ? 32'((1 << (m_owner + 1)) - 1) : 32'd0;
    check_outs(tag, rq, id, cs, sv, m_pend, m_mask);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (clr) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic set_in(input logic [2:0] s, input logic mw, input logic [2:0] md,
                        input logic [2:0] pc, input logic blk, input logic ak, input logic er);
    src = s; mask_we = mw; mask_wdata = md; pend_clr = pc; int_block = blk;
    bus.exc_ack = ak; bus.eret = er;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    set_in(3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    model_reset();
    #2;
    check_outs("reset", 1'b0, 2'd0, 32'd0, 1'b0, 3'b000, 3'b000);
    cycle();
    cycle();
    clr = 1'b0;

    // T1: single event latency
    vecs.push_back(mk(3'b010,0,3'b000,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b010,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 1,2'd1,32'h3,0,3'b010,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,1,0, 0,2'd1,32'h3,1,3'b000,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b000,3'b000));
    // T2: simultaneous rises served in priority order
    vecs.push_back(mk(3'b111,0,3'b000,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b111,3'b000));
    vecs.push_back(mk(3'b111,0,3'b000,3'b000,0,0,0, 1,2'd0,32'h1,0,3'b111,3'b000));
    vecs.push_back(mk(3'b111,0,3'b000,3'b000,0,1,0, 0,2'd0,32'h1,1,3'b110,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b110,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 1,2'd1,32'h3,0,3'b110,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,1,0, 0,2'd1,32'h3,1,3'b100,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b100,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 1,2'd2,32'h7,0,3'b100,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,1,0, 0,2'd2,32'h7,1,3'b000,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b000,3'b000));
    // T3: masked source latches but does not request until unmasked
    vecs.push_back(mk(3'b000,1,3'b001,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b000,3'b001));
    vecs.push_back(mk(3'b001,0,3'b000,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b001,3'b001));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b001,3'b001));
    vecs.push_back(mk(3'b000,1,3'b000,3'b000,0,0,0, 0,2'd0,32'h0,0,3'b001,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 1,2'd0,32'h1,0,3'b001,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,1,0, 0,2'd0,32'h1,1,3'b000,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b000,3'b000));
    // T4: global block holds off entry but cannot withdraw a request
    vecs.push_back(mk(3'b100,0,3'b000,3'b000,1,0,0, 0,2'd0,32'h0,0,3'b100,3'b000));
    vecs.push_back(mk(3'b100,0,3'b000,3'b000,1,0,0, 0,2'd0,32'h0,0,3'b100,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,0, 1,2'd2,32'h7,0,3'b100,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,1,0,0, 1,2'd2,32'h7,0,3'b100,3'b000));
    vecs.push_back(mk(3'b000,1,3'b100,3'b100,1,0,0, 1,2'd2,32'h7,0,3'b000,3'b100));
    vecs.push_back(mk(3'b000,1,3'b000,3'b000,0,1,0, 0,2'd2,32'h7,1,3'b000,3'b000));
    vecs.push_back(mk(3'b000,0,3'b000,3'b000,0,0,1, 0,2'd0,32'h0,0,3'b000,3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].src, vecs[i].mask_we, vecs[i].mask_wdata, vecs[i].pend_clr,
             vecs[i].int_block, vecs[i].ack, vecs[i].eret);
      cycle();
      check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].id, vecs[i].cause,
                 vecs[i].svc, vecs[i].pend, vecs[i].msk);
    end

    // T5: new event on the granted source in the acknowledge cycle survives
    set_in(3'b001, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    check_outs("t5.req", 1'b1, 2'd0, 32'h1, 1'b0, 3'b001, 3'b000);
    set_in(3'b001, 0, 3'b000, 3'b000, 0, 1, 0); cycle();
    check_outs("t5.ack", 1'b0, 2'd0, 32'h1, 1'b1, 3'b001, 3'b000);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    check_outs("t5.svc", 1'b0, 2'd0, 32'h1, 1'b1, 3'b001, 3'b000);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 1); cycle();
    check_outs("t5.eret", 1'b0, 2'd0, 32'h0, 1'b0, 3'b001, 3'b000);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    check_outs("t5.rereq", 1'b1, 2'd0, 32'h1, 1'b0, 3'b001, 3'b000);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 1, 0); cycle();
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 1); cycle();
    check_outs("t5.done", 1'b0, 2'd0, 32'h0, 1'b0, 3'b000, 3'b000);

    // T6: asynchronous clear while in SERVICE
    set_in(3'b010, 1, 3'b100, 3'b000, 0, 0, 0); cycle();
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 1, 0); cycle();
    set_in(3'b100, 0, 3'b000, 3'b000, 0, 0, 0); cycle();
    check_outs("t6.pre", 1'b0, 2'd1, 32'h3, 1'b1, 3'b100, 3'b100);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0);
    #2;
    clr = 1'b1;
    #1;
    check_outs("t6.async", 1'b0, 2'd0, 32'h0, 1'b0, 3'b000, 3'b000);
    cycle();
    clr = 1'b0;
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 1); cycle();
    check_outs("t6.eret", 1'b0, 2'd0, 32'h0, 1'b0, 3'b000, 3'b000);
    set_in(3'b000, 0, 3'b000, 3'b000, 0, 0, 0); cycle();

    // Randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) src[2'(b)] = ~src[2'(b)];
      mask_we     = ($urandom_range(0, 7) == 0);
      mask_wdata  = 3'($urandom_range(0, 7));
      pend_clr    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      int_block   = ($urandom_range(0, 3) == 0);
      bus.exc_ack = ($urandom_range(0, 1) == 1);
      bus.eret    = ($urandom_range(0, 2) == 0);
      clr         = ($urandom_range(0, 99) == 0);
      cycle();
      model_check($sformatf("rnd%0d", n));
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
